// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch unit feeding a DEPTH-entry {pc, bundle} FIFO, with redirect flush.
// Define FETCH_QUEUE_STATS_EN to add saturating stall_cnt / flush_cnt outputs.
module fetch_queue #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [8:0]  imem_addr,
   input  logic [63:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [9:0]  redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_bundle,
   output logic [9:0]  out_pc,
`ifdef FETCH_QUEUE_STATS_EN
   output logic [15:0] stall_cnt,
   output logic [15:0] flush_cnt,
`endif
   output logic [4:0]  level
);

   localparam int               PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [4:0]       DEPTH_L = 5'(DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1'b1);

   typedef struct packed {
      logic [9:0]  pc;
      logic [63:0] bundle;
   } entry_t;

   entry_t           mem_q [DEPTH];
   entry_t           mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [4:0]       level_q, level_d;
   logic [9:0]       fetch_pc_q, fetch_pc_d;
   logic             inflight_q, inflight_d;
   logic [9:0]       inflight_pc_q, inflight_pc_d;
   logic             req_s;
   logic             push_s;
   logic             pop_s;

   // Decode request/push/pop for this cycle; reset and redirect suppress all three.
   always_comb begin
      req_s  = 1'b0;
      push_s = 1'b0;
      pop_s  = 1'b0;
      if (rst || redirect_valid) begin
         req_s  = 1'b0;
         push_s = 1'b0;
         pop_s  = 1'b0;
      end else begin
         req_s  = ((level_q + {4'b0000, inflight_q}) < DEPTH_L);
         push_s = inflight_q;
         pop_s  = (level_q != 5'd0) && out_ready;
      end
   end

   // Next-state for fetch PC, in-flight tracking and FIFO storage.
   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      inflight_d    = req_s;
      inflight_pc_d = inflight_pc_q;
      level_d       = level_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      mem_d         = mem_q;
      if (redirect_valid) begin
         fetch_pc_d = redirect_pc & 10'h3FE;
         level_d    = 5'd0;
         wr_ptr_d   = {PTR_W{1'b0}};
         rd_ptr_d   = {PTR_W{1'b0}};
      end else begin
         if (req_s) begin
            fetch_pc_d    = fetch_pc_q + 10'd2;
            inflight_pc_d = fetch_pc_q;
         end else begin
            fetch_pc_d    = fetch_pc_q;
            inflight_pc_d = inflight_pc_q;
         end
         if (push_s) begin
            mem_d[wr_ptr_q] = '{pc: inflight_pc_q, bundle: imem_rdata};
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         level_d = level_q + {4'b0000, push_s} - {4'b0000, pop_s};
      end
   end

   // State registers; storage is cleared on reset so the head reads zero afterwards.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_q    <= 10'd0;
         inflight_q    <= 1'b0;
         inflight_pc_q <= 10'd0;
         level_q       <= 5'd0;
         wr_ptr_q      <= {PTR_W{1'b0}};
         rd_ptr_q      <= {PTR_W{1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
         level_q       <= level_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
      end
   end

   assign imem_req   = req_s;
   assign imem_addr  = fetch_pc_q[9:1];
   assign level      = level_q;
   assign out_valid  = (level_q != 5'd0);
   assign out_pc     = mem_q[rd_ptr_q].pc;
   assign out_bundle = mem_q[rd_ptr_q].bundle;

`ifdef FETCH_QUEUE_STATS_EN
   logic [15:0] stall_cnt_q, stall_cnt_d;
   logic [15:0] flush_cnt_q, flush_cnt_d;

   // Saturating event counters.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (out_valid && !out_ready && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
      if (redirect_valid && (flush_cnt_q != 16'hFFFF)) begin
         flush_cnt_d = flush_cnt_q + 16'd1;
      end else begin
         flush_cnt_d = flush_cnt_q;
      end
   end

   // Counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= 16'd0;
         flush_cnt_q <= 16'd0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed + random stimulus against a queue-based reference model of fetch_queue.
// Statistics checks are compiled in when FETCH_QUEUE_STATS_EN is defined.
module tb_fetch_queue;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [8:0]  imem_addr;
   logic [63:0] imem_rdata;
   logic        redirect_valid;
   logic [9:0]  redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_bundle;
   logic [9:0]  out_pc;
   logic [4:0]  level;
`ifdef FETCH_QUEUE_STATS_EN
   logic [15:0] stall_cnt;
   logic [15:0] flush_cnt;
`endif

   always #5 clk = ~clk;

   fetch_queue #(.DEPTH(DEPTH)) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_bundle     (out_bundle),
      .out_pc         (out_pc),
`ifdef FETCH_QUEUE_STATS_EN
      .stall_cnt      (stall_cnt),
      .flush_cnt      (flush_cnt),
`endif
      .level          (level)
   );

   // Instruction ROM: bundle i = {i, ~i}, one cycle after the strobe; junk otherwise.
   always @(posedge clk) begin
      if (imem_req) imem_rdata <= {{23'd0, imem_addr}, ~{23'd0, imem_addr}};
      else          imem_rdata <= {$urandom, $urandom};
   end

   // Reference model: queue of bundle PCs plus the one outstanding request.
   logic [9:0]  m_q[$];
   bit          m_pend;
   logic [9:0]  m_pend_pc;
   logic [9:0]  m_pc;
   bit          m_zero_head;
   int unsigned m_stall, m_flush;

   int checks = 0;
   int passed = 0;
   int failed = 0;

   function automatic logic [63:0] rom_word(input logic [9:0] pc);
      logic [31:0] idx;
      idx = {23'd0, pc[9:1]};
      return {idx, ~idx};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input bit r, input bit rv, input logic [9:0] rp, input bit rdy);
      bit exp_req;
      bit do_pop;
      @(negedge clk);
      rst = r; redirect_valid = rv; redirect_pc = rp; out_ready = rdy;
      #1;
      exp_req = !r && !rv && ((m_q.size() + (m_pend ? 1 : 0)) < DEPTH);
      check("imem_req", 64'(imem_req), 64'(exp_req));
      check("imem_addr", 64'(imem_addr), 64'(m_pc[9:1]));
      check("level", 64'(level), 64'(m_q.size()));
      check("out_valid", 64'(out_valid), 64'(m_q.size() != 0));
      if (m_q.size() != 0) begin
         check("out_pc", 64'(out_pc), 64'(m_q[0]));
         check("out_bundle", out_bundle, rom_word(m_q[0]));
      end else if (m_zero_head) begin
         check("reset_out_pc", 64'(out_pc), 64'd0);
         check("reset_out_bundle", out_bundle, 64'd0);
      end
`ifdef FETCH_QUEUE_STATS_EN
      check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
      check("flush_cnt", 64'(flush_cnt), 64'(m_flush));
`endif
      @(posedge clk);
      do_pop = (m_q.size() != 0) && rdy;
      if (r) begin
         m_stall = 0;
         m_flush = 0;
      end else begin
         if ((m_q.size() != 0) && !rdy && (m_stall < 65535)) m_stall++;
         if (rv && (m_flush < 65535)) m_flush++;
      end
      m_zero_head = r;
      if (r) begin
         m_q.delete(); m_pend = 0; m_pc = 10'd0;
      end else if (rv) begin
         m_q.delete(); m_pend = 0; m_pc = {rp[9:1], 1'b0};
      end else begin
         if (do_pop) void'(m_q.pop_front());
         if (m_pend) m_q.push_back(m_pend_pc);
         m_pend = exp_req;
         if (exp_req) begin
            m_pend_pc = m_pc;
            m_pc      = m_pc + 10'd2;
         end
      end
   endtask

   initial begin
      rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 10'd0; out_ready = 1'b0;
      m_pend = 0; m_pend_pc = 10'd0; m_pc = 10'd0; m_zero_head = 1; m_stall = 0; m_flush = 0;
      repeat (2) @(posedge clk);

      // Reset held, then release with out_ready=1: sequential fetch from 0.
      repeat (2) step(1, 0, 10'd0, 1);
      repeat (16) step(0, 0, 10'd0, 1);

      // Consumer stalls for 20 cycles: FIFO fills and fetch stops.
      repeat (20) step(0, 0, 10'd0, 0);
      #1;
      check("stall_full_level", 64'(level), 64'(DEPTH));
      check("stall_no_req", 64'(imem_req), 64'd0);
      repeat (8) step(0, 0, 10'd0, 1);

      // Redirect to 0x101 with level=3 and one request in flight.
      step(1, 0, 10'd0, 1);
      for (int i = 0; i < 12 && !(m_q.size() == 3 && m_pend); i++) step(0, 0, 10'd0, 0);
      check("redir_setup_level", 64'(m_q.size()), 64'd3);
      step(0, 1, 10'h101, 1);
      #1;
      check("redir_level_cleared", 64'(level), 64'd0);
      check("redir_next_addr", 64'(imem_addr), 64'h080);
      repeat (8) step(0, 0, 10'd0, 1);

      // Redirect colliding with a pop and a returning response.
      step(0, 1, 10'h200, 1);
      #1;
      check("collide_empty", 64'(out_valid), 64'd0);
      repeat (4) step(0, 0, 10'd0, 1);

      // PC wrap-around.
      step(0, 1, 10'h3FC, 1);
      repeat (8) step(0, 0, 10'd0, 1);

      // Back-to-back redirects: only the last target is fetched.
      step(0, 1, 10'h050, 1);
      step(0, 1, 10'h300, 1);
      repeat (6) step(0, 0, 10'd0, 1);

      // Reset in mid-operation.
      repeat (3) step(0, 0, 10'd0, 0);
      step(1, 0, 10'd0, 1);
      repeat (6) step(0, 0, 10'd0, 1);

      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(99) == 0), ($urandom_range(19) == 0), 10'($urandom),
              ($urandom_range(3) != 0));
      end

`ifdef FETCH_QUEUE_STATS_EN
      // Five stalled cycles and two redirects, then long-stall saturation.
      step(1, 0, 10'd0, 1);
      repeat (4) step(0, 0, 10'd0, 1);
      repeat (5) step(0, 0, 10'd0, 0);
      step(0, 1, 10'h010, 1);
      step(0, 1, 10'h020, 1);
      #1;
      check("stats_stall_5", 64'(stall_cnt), 64'd5);
      check("stats_flush_2", 64'(flush_cnt), 64'd2);
      step(1, 0, 10'd0, 0);
      repeat (65540) step(0, 0, 10'd0, 0);
      #1;
      check("stats_stall_sat", 64'(stall_cnt), 64'hFFFF);
`endif

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
